pipe_hazard_stage: RTL and testbench

ID/EX pipeline register of PipeCPU, fused with load-use interlock and EX-stage operand forwarding. Sits between decode (register-file read) and the ALU, and consumes EX/MEM and MEM/WB writeback info for bypassing. Guarantees back-to-back dependent instructions (add t3,t1,t2; sw t3,3(zero)) see correct operands without software NOPs.

---
 rtl/pipe_hazard_stage_pkg.sv | 25 ++
 rtl/pipe_forward_mux.sv | 41 ++++
 rtl/pipe_hazard_stage.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_stage_pkg.sv
// Shared constants for the PipeCPU ID/EX hazard stage: datapath widths,
// control-bundle field offsets and the operand forward-select encoding.
package pipe_hazard_stage_pkg;

  localparam int PIPE_WIDTH     = 32;
  localparam int PIPE_REG_BITS  = 5;
  localparam int PIPE_CTRL_BITS = 16;

  localparam logic [PIPE_REG_BITS-1:0] ZERO_REG = '0;

  // Field layout of the opaque control bundle; decoded only in EX.
  localparam int CTRL_ALU_OP_LSB  = 0;
  localparam int CTRL_ALU_OP_BITS = 4;
  localparam int CTRL_ALU_SRC     = 4;
  localparam int CTRL_MEM_WRITE   = 5;
  localparam int CTRL_BRANCH      = 6;
  localparam int CTRL_JUMP        = 7;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/pipe_forward_mux.sv
// One EX operand bypass: picks EX/MEM, then MEM/WB, then the stored
// register-file value; register zero is never bypassed.
module pipe_forward_mux
  import pipe_hazard_stage_pkg::*;
#(
  parameter int WIDTH    = PIPE_WIDTH,
  parameter int REG_BITS = PIPE_REG_BITS
) (
  input  logic [REG_BITS-1:0] spec,
  input  logic [WIDTH-1:0]    reg_data,
  input  logic                mem_reg_write,
  input  logic [REG_BITS-1:0] mem_dest,
  input  logic [WIDTH-1:0]    mem_result,
  input  logic                wb_reg_write,
  input  logic [REG_BITS-1:0] wb_dest,
  input  logic [WIDTH-1:0]    wb_result,
  output logic [WIDTH-1:0]    value
);

  fwd_sel_e sel;

  // The younger EX/MEM producer takes precedence over MEM/WB.
  always_comb begin
    sel = FWD_REG;
    if (spec != '0 && mem_reg_write && mem_dest == spec) begin
      sel = FWD_MEM;
    end else if (spec != '0 && wb_reg_write && wb_dest == spec) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    value = reg_data;
    case (sel)
      FWD_MEM: value = mem_result;
      FWD_WB:  value = wb_result;
      default: value = reg_data;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_stage.sv
// PipeCPU ID/EX register with load-use interlock and EX operand forwarding.
// Define PIPE_ID_BYPASS_EN for a read-before-write register file (WB bypass at capture).
module pipe_hazard_stage
  import pipe_hazard_stage_pkg::*;
#(
  parameter int WIDTH     = PIPE_WIDTH,
  parameter int REG_BITS  = PIPE_REG_BITS,
  parameter int CTRL_BITS = PIPE_CTRL_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_BITS-1:0]  id_rs,
  input  logic [REG_BITS-1:0]  id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic [WIDTH-1:0]     id_rs_data,
  input  logic [WIDTH-1:0]     id_rt_data,
  input  logic [WIDTH-1:0]     id_imm,
  input  logic [REG_BITS-1:0]  id_dest,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic [CTRL_BITS-1:0] id_ctrl,
  input  logic                 flush,
  input  logic                 mem_reg_write,
  input  logic [REG_BITS-1:0]  mem_dest,
  input  logic [WIDTH-1:0]     mem_result,
  input  logic                 wb_reg_write,
  input  logic [REG_BITS-1:0]  wb_dest,
  input  logic [WIDTH-1:0]     wb_result,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [WIDTH-1:0]     ex_a,
  output logic [WIDTH-1:0]     ex_b,
  output logic [WIDTH-1:0]     ex_imm,
  output logic [REG_BITS-1:0]  ex_dest,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic [CTRL_BITS-1:0] ex_ctrl
);

  logic [REG_BITS-1:0] ex_rs;
  logic [REG_BITS-1:0] ex_rt;
  logic [WIDTH-1:0]    ex_rs_data;
  logic [WIDTH-1:0]    ex_rt_data;
  logic [WIDTH-1:0]    cap_rs_data;
  logic [WIDTH-1:0]    cap_rt_data;
  logic                load_use;

  // A load in EX whose result ID needs cannot be bypassed yet: hold ID one cycle.
  assign load_use = id_valid & ex_valid & ex_mem_read & (ex_dest != '0) &
                    ((id_use_rs & (id_rs == ex_dest)) | (id_use_rt & (id_rt == ex_dest)));
  assign stall    = load_use & ~flush & ~reset;

`ifdef PIPE_ID_BYPASS_EN
  assign cap_rs_data = (wb_reg_write && wb_dest == id_rs && id_rs != '0) ? wb_result : id_rs_data;
  assign cap_rt_data = (wb_reg_write && wb_dest == id_rt && id_rt != '0) ? wb_result : id_rt_data;
`else
  assign cap_rs_data = id_rs_data;
  assign cap_rt_data = id_rt_data;
`endif

  // Bubbles clear only the fields that can change architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_dest      <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_rs_data   <= cap_rs_data;
      ex_rt_data   <= cap_rt_data;
      ex_imm       <= id_imm;
      ex_dest      <= id_valid ? id_dest : '0;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
    end
  end

  pipe_forward_mux #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_fwd_a (
    .spec          (ex_rs),
    .reg_data      (ex_rs_data),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .wb_result     (wb_result),
    .value         (ex_a)
  );

  pipe_forward_mux #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_fwd_b (
    .spec          (ex_rt),
    .reg_data      (ex_rt_data),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .wb_result     (wb_result),
    .value         (ex_b)
  );

endmodule

// File: tb/tb_pipe_hazard_stage.sv
// Directed table-driven bench for pipe_hazard_stage: forwarding, load-use
// interlock, flush priority, bubbles and asynchronous reset.
module tb_pipe_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_dest;
  logic        id_reg_write, id_mem_read;
  logic [15:0] id_ctrl;
  logic        flush;
  logic        mem_reg_write;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_result;
  logic        stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read;
  logic [15:0] ex_ctrl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .flush(flush), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
    .wb_result(wb_result), .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a),
    .ex_b(ex_b), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl)
  );

  typedef struct {
    logic v; logic [4:0] rs, rt; logic urs, urt;
    logic [31:0] rsd, rtd, imm; logic [4:0] dest; logic rw, mr;
    logic [15:0] ctrl; logic flush;
  } id_t;

  typedef struct {
    logic mrw; logic [4:0] md; logic [31:0] mres;
    logic wrw; logic [4:0] wd; logic [31:0] wres;
  } env_t;

  typedef struct {
    logic stall, valid, chk; logic [31:0] a, b, imm;
    logic [4:0] dest; logic rw, mr; logic [15:0] ctrl;
  } exp_t;

  typedef struct { id_t id; env_t env; exp_t ex; } vec_t;

  function automatic id_t mkId(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                               logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                               logic [4:0] dest, logic rw, logic mr, logic [15:0] ctrl, logic fl);
    id_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rsd = rsd; r.rtd = rtd;
    r.imm = imm; r.dest = dest; r.rw = rw; r.mr = mr; r.ctrl = ctrl; r.flush = fl;
    return r;
  endfunction

  function automatic env_t mkEnv(logic mrw, logic [4:0] md, logic [31:0] mres,
                                 logic wrw, logic [4:0] wd, logic [31:0] wres);
    env_t r;
    r.mrw = mrw; r.md = md; r.mres = mres; r.wrw = wrw; r.wd = wd; r.wres = wres;
    return r;
  endfunction

  function automatic exp_t mkExp(logic st, logic v, logic chk, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] imm, logic [4:0] dest, logic rw, logic mr,
                                 logic [15:0] ctrl);
    exp_t r;
    r.stall = st; r.valid = v; r.chk = chk; r.a = a; r.b = b; r.imm = imm;
    r.dest = dest; r.rw = rw; r.mr = mr; r.ctrl = ctrl;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveEnv(input env_t e);
    mem_reg_write = e.mrw; mem_dest = e.md; mem_result = e.mres;
    wb_reg_write  = e.wrw; wb_dest  = e.wd; wb_result  = e.wres;
  endtask

  task automatic driveId(input id_t d);
    id_valid = d.v; id_rs = d.rs; id_rt = d.rt; id_use_rs = d.urs; id_use_rt = d.urt;
    id_rs_data = d.rsd; id_rt_data = d.rtd; id_imm = d.imm; id_dest = d.dest;
    id_reg_write = d.rw; id_mem_read = d.mr; id_ctrl = d.ctrl; flush = d.flush;
  endtask

  // ID fields are driven mid-cycle, stall is sampled before the edge, and the
  // downstream producers seen by the new EX instruction are set after it.
  task automatic applyStimulus(input int idx, input vec_t t);
    string tag;
    tag = $sformatf("v%0d", idx);
    driveId(t.id);
    #2;
    checkOutput({tag, ".stall"}, {31'd0, stall}, {31'd0, t.ex.stall});
    @(posedge clk);
    #1;
    driveEnv(t.env);
    #1;
    checkOutput({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, t.ex.valid});
    checkOutput({tag, ".ex_dest"}, {27'd0, ex_dest}, {27'd0, t.ex.dest});
    checkOutput({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, t.ex.rw});
    checkOutput({tag, ".ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, t.ex.mr});
    checkOutput({tag, ".ex_ctrl"}, {16'd0, ex_ctrl}, {16'd0, t.ex.ctrl});
    if (t.ex.chk) begin
      checkOutput({tag, ".ex_a"}, ex_a, t.ex.a);
      checkOutput({tag, ".ex_b"}, ex_b, t.ex.b);
      checkOutput({tag, ".ex_imm"}, ex_imm, t.ex.imm);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
    checkOutput({tag, ".ex_a"}, ex_a, 32'd0);
    checkOutput({tag, ".ex_b"}, ex_b, 32'd0);
    checkOutput({tag, ".ex_imm"}, ex_imm, 32'd0);
    checkOutput({tag, ".ex_dest"}, {27'd0, ex_dest}, 32'd0);
    checkOutput({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
    checkOutput({tag, ".ex_mem_read"}, {31'd0, ex_mem_read}, 32'd0);
    checkOutput({tag, ".ex_ctrl"}, {16'd0, ex_ctrl}, 32'd0);
  endtask

  vec_t vecs[21];
  env_t none;
  exp_t bub;

  initial begin
    none = mkEnv(0, 0, 0, 0, 0, 0);
    bub  = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    // t1=9 t2=10 t3=11 t4=12 t5=13 t6=14 t7=15
    vecs[0]  = '{mkId(1, 0, 0, 1, 0, 0, 0, 3, 9, 1, 0, 16'h0101, 0), none,
                 mkExp(0, 1, 1, 0, 0, 3, 9, 1, 0, 16'h0101)};
    vecs[1]  = '{mkId(1, 0, 0, 1, 0, 0, 0, 3, 10, 1, 0, 16'h0101, 0), mkEnv(1, 9, 3, 0, 0, 0),
                 mkExp(0, 1, 1, 0, 0, 3, 10, 1, 0, 16'h0101)};
    vecs[2]  = '{mkId(1, 9, 10, 1, 1, 32'h111, 32'h222, 0, 11, 1, 0, 16'h0020, 0),
                 mkEnv(1, 10, 3, 1, 9, 3), mkExp(0, 1, 1, 3, 3, 0, 11, 1, 0, 16'h0020)};
    vecs[3]  = '{mkId(1, 0, 0, 1, 0, 0, 0, 3, 12, 1, 1, 16'h0403, 0), mkEnv(1, 11, 6, 1, 10, 3),
                 mkExp(0, 1, 1, 0, 0, 3, 12, 1, 1, 16'h0403)};
    vecs[4]  = '{mkId(1, 12, 11, 1, 1, 32'h444, 32'h333, 0, 13, 1, 0, 16'h0020, 0),
                 mkEnv(1, 12, 3, 1, 11, 6), bub};
    vecs[4].ex.stall = 1'b1;
    vecs[5]  = '{mkId(1, 12, 11, 1, 1, 32'h444, 6, 0, 13, 1, 0, 16'h0020, 0),
                 mkEnv(0, 0, 0, 1, 12, 3), mkExp(0, 1, 1, 3, 6, 0, 13, 1, 0, 16'h0020)};
    vecs[6]  = '{mkId(1, 9, 9, 1, 1, 32'h555, 32'h555, 0, 14, 1, 0, 16'h0020, 0),
                 mkEnv(1, 9, 7, 1, 9, 5), mkExp(0, 1, 1, 7, 7, 0, 14, 1, 0, 16'h0020)};
    vecs[7]  = '{mkId(1, 9, 10, 1, 1, 32'h555, 32'h666, 0, 14, 1, 0, 16'h0020, 0),
                 mkEnv(1, 10, 32'h77, 1, 9, 32'h55), mkExp(0, 1, 1, 32'h55, 32'h77, 0, 14, 1, 0, 16'h0020)};
    vecs[8]  = '{mkId(1, 0, 0, 1, 1, 0, 0, 32'h10, 15, 1, 0, 16'h0030, 0),
                 mkEnv(1, 0, 32'hDEADBEEF, 1, 0, 32'hCAFEF00D),
                 mkExp(0, 1, 1, 0, 0, 32'h10, 15, 1, 0, 16'h0030)};
    vecs[9]  = '{mkId(1, 0, 0, 1, 0, 0, 0, 8, 12, 1, 1, 16'h0403, 0), none,
                 mkExp(0, 1, 1, 0, 0, 8, 12, 1, 1, 16'h0403)};
    vecs[10] = '{mkId(1, 12, 0, 1, 0, 32'h444, 0, 0, 13, 1, 0, 16'h0020, 1), none, bub};
    vecs[11] = '{mkId(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 16'h00FF, 0), none, bub};
    vecs[12] = '{mkId(1, 0, 0, 1, 0, 0, 0, 4, 15, 1, 1, 16'h0403, 0), none,
                 mkExp(0, 1, 1, 0, 0, 4, 15, 1, 1, 16'h0403)};
    vecs[13] = '{mkId(1, 15, 15, 0, 0, 1, 2, 9, 16, 1, 0, 16'h0040, 0), mkEnv(1, 15, 4, 0, 0, 0),
                 mkExp(0, 1, 1, 4, 4, 9, 16, 1, 0, 16'h0040)};
    vecs[14] = '{mkId(1, 0, 0, 1, 0, 0, 0, 4, 15, 1, 1, 16'h0403, 0), none,
                 mkExp(0, 1, 1, 0, 0, 4, 15, 1, 1, 16'h0403)};
    vecs[15] = '{mkId(1, 0, 15, 1, 1, 0, 32'h99, 0, 0, 0, 0, 16'h0800, 0),
                 mkEnv(1, 15, 4, 0, 0, 0), bub};
    vecs[15].ex.stall = 1'b1;
    vecs[16] = '{mkId(1, 0, 15, 1, 1, 0, 32'h99, 0, 0, 0, 0, 16'h0800, 0),
                 mkEnv(0, 0, 0, 1, 15, 32'h77), mkExp(0, 1, 1, 0, 32'h77, 0, 0, 0, 0, 16'h0800)};
    vecs[17] = '{mkId(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0403, 0), none,
                 mkExp(0, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0403)};
    vecs[18] = '{mkId(1, 0, 0, 1, 1, 0, 0, 0, 17, 1, 0, 16'h0020, 0), none,
                 mkExp(0, 1, 1, 0, 0, 0, 17, 1, 0, 16'h0020)};
    vecs[19] = '{mkId(1, 0, 0, 1, 0, 0, 0, 8, 12, 1, 1, 16'h0403, 0), none,
                 mkExp(0, 1, 1, 0, 0, 8, 12, 1, 1, 16'h0403)};
    vecs[20] = '{mkId(0, 12, 0, 1, 0, 0, 0, 0, 13, 1, 0, 16'h0020, 0), none, bub};

    reset = 1'b1;
    driveId(mkId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));
    driveEnv(none);
    #7;
    checkAllZero("reset");
    #5;
    reset = 1'b0;

    for (int i = 0; i < 21; i++) applyStimulus(i, vecs[i]);

    // Mid-stream asynchronous reset with a live load in EX and a dependent in ID.
    driveId(mkId(1, 9, 0, 1, 0, 32'h123, 0, 5, 3, 1, 1, 16'hABCD, 0));
    driveEnv(none);
    @(posedge clk);
    #1;
    checkOutput("pre_rst.ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("pre_rst.ex_a", ex_a, 32'h123);
    driveId(mkId(1, 3, 0, 1, 0, 0, 0, 0, 4, 1, 0, 16'h0020, 0));
    #1;
    checkOutput("pre_rst.stall", {31'd0, stall}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkAllZero("mid_rst");
    @(posedge clk);
    #2;
    checkAllZero("held_rst");
    reset = 1'b0;
    driveId(mkId(1, 8, 9, 1, 1, 32'h42, 32'h43, 32'h6, 21, 1, 0, 16'h0055, 0));
    @(posedge clk);
    #1;
    checkOutput("post_rst.ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("post_rst.ex_a", ex_a, 32'h42);
    checkOutput("post_rst.ex_b", ex_b, 32'h43);
    checkOutput("post_rst.ex_imm", ex_imm, 32'h6);
    checkOutput("post_rst.ex_dest", {27'd0, ex_dest}, 32'd21);
    checkOutput("post_rst.ex_ctrl", {16'd0, ex_ctrl}, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
